// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_CH strobe-read channel FIFOs into one valid/ready word stream.
// Round-robin grant with optional half-full priority; one read strobe per grant.
module fifo_drain_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_WIDTH = 63,
  parameter int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter bit PRIO_HALF  = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH-1:0]            fifo_half,
  input  logic [NUM_CH*FIFO_WIDTH-1:0] fifo_data,
  output logic [NUM_CH-1:0]            read_n,
  output logic [FIFO_WIDTH-1:0]        word_out,
  output logic [CH_BITS-1:0]           word_ch,
  output logic                         word_parity,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         words_sent
);

  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  state_t                 state_reg;
  logic [CH_BITS-1:0]     grant_reg;
  logic [CH_BITS-1:0]     rr_ptr_reg;
  logic [NUM_CH-1:0]      read_n_reg;
  logic [FIFO_WIDTH-1:0]  word_out_reg;
  logic [CH_BITS-1:0]     word_ch_reg;
  logic                   word_parity_reg;
  logic                   word_valid_reg;
  logic [CNT_WIDTH-1:0]   words_sent_reg;

  logic [NUM_CH-1:0]      req;
  logic [NUM_CH-1:0]      search_set;
  logic [NUM_CH-1:0]      grant_onehot;
  logic [CH_BITS-1:0]     grant_next;
  logic                   grant_found;
  logic [FIFO_WIDTH-1:0]  ch_data [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]      = fifo_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
      assign grant_onehot[gi] = (grant_next == CH_BITS'(gi));
    end
  endgenerate

  // Half-full channels form the search set whenever any of them is requesting.
  always_comb begin
    int idx;
    idx         = 0;
    req         = ~fifo_empty;
    search_set  = (PRIO_HALF && (|(req & fifo_half))) ? (req & fifo_half) : req;
    grant_next  = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && (|(search_set & (CH_ONE << idx)))) begin
        grant_found = 1'b1;
        grant_next  = CH_BITS'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      rr_ptr_reg      <= '0;
      read_n_reg      <= '1;
      word_out_reg    <= '0;
      word_ch_reg     <= '0;
      word_parity_reg <= 1'b0;
      word_valid_reg  <= 1'b0;
      words_sent_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable && grant_found) begin
            grant_reg  <= grant_next;
            read_n_reg <= ~grant_onehot;
            if (grant_next == CH_BITS'(NUM_CH - 1)) rr_ptr_reg <= '0;
            else                                    rr_ptr_reg <= grant_next + 1'b1;
            state_reg  <= READ;
          end
        end
        READ: begin
          // The FIFO presented the strobed word on the falling edge of this cycle.
          word_out_reg    <= ch_data[grant_reg];
          word_ch_reg     <= grant_reg;
          word_parity_reg <= ~(^{grant_reg, ch_data[grant_reg]});
          word_valid_reg  <= 1'b1;
          read_n_reg      <= '1;
          state_reg       <= SEND;
        end
        SEND: begin
          if (word_ready) begin
            word_valid_reg <= 1'b0;
            words_sent_reg <= words_sent_reg + 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          read_n_reg     <= '1;
          word_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign read_n      = read_n_reg;
  assign word_out    = word_out_reg;
  assign word_ch     = word_ch_reg;
  assign word_parity = word_parity_reg;
  assign word_valid  = word_valid_reg;
  assign words_sent  = words_sent_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: behavioural strobe-read FIFOs feed the DUT,
// expected words are queued as stimulus is loaded and compared at each handshake.
module tb_fifo_drain_arbiter;

  localparam int NCH = 4;
  localparam int W   = 63;
  localparam int CB  = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [NCH-1:0]    fifo_empty = '1;
  logic [NCH-1:0]    fifo_half = '0;
  logic [NCH*W-1:0]  fifo_data = '0;
  logic [NCH-1:0]    read_n;
  logic [W-1:0]      word_out;
  logic [CB-1:0]     word_ch;
  logic              word_parity;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic              busy;
  logic [15:0]       words_sent;

  fifo_drain_arbiter #(
    .NUM_CH(NCH), .FIFO_WIDTH(W), .CH_BITS(CB), .PRIO_HALF(1'b1), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_half(fifo_half), .fifo_data(fifo_data),
    .read_n(read_n), .word_out(word_out), .word_ch(word_ch),
    .word_parity(word_parity), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CB-1:0] ch;
    logic [W-1:0]  word;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] fq[NCH][$];
  int           strobe_ch[$];
  int           strobe_cyc[$];
  int           hs_cyc[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  exp_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // FIFO model and output monitor share one process so pop and check are ordered.
  always @(negedge clk) begin
    if (reset_n && read_n != '1) begin
      check_eq("strobe_onehot", 64'($onehot(~read_n)), 64'd1);
      for (int i = 0; i < NCH; i++) begin
        if (!read_n[i]) begin
          check_eq("strobe_nonempty", 64'(fq[i].size() > 0), 64'd1);
          strobe_ch.push_back(i);
          strobe_cyc.push_back(cyc);
          if (fq[i].size() > 0) fifo_data[i*W +: W] = fq[i].pop_front();
          fifo_empty[i] = (fq[i].size() == 0);
        end
      end
    end
    if (reset_n && word_valid && word_ready) begin
      hs_cyc.push_back(cyc);
      check_eq("parity_odd", 64'(^{word_ch, word_out, word_parity}), 64'd1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("word_ch", 64'(word_ch), 64'(mon_e.ch));
        check_eq("word_out", 64'(word_out), 64'(mon_e.word));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [W-1:0] w);
    fq[ch].push_back(w);
    fifo_empty[ch] = 1'b0;
  endtask

  task automatic expect_word(input int ch, input logic [W-1:0] w);
    exp_t e;
    e.ch   = CB'(ch);
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic clear_logs();
    strobe_ch.delete();
    strobe_cyc.delete();
    hs_cyc.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    for (int i = 0; i < NCH; i++) fq[i].delete();
    fifo_empty = '1;
    fifo_half  = '0;
    fifo_data  = '0;
    exp_q.delete();
    clear_logs();
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_drain_done"}, 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom(), $urandom()});
  endfunction

  logic [W-1:0] wv [8];
  logic [W-1:0] held_word;
  int           n;

  initial begin
    // Reset with every FIFO empty: nothing may be strobed or sent.
    apply_reset();
    enable = 1'b1;
    word_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("t1_read_n_idle", 64'(read_n), 64'hF);
      check_eq("t1_valid_low", 64'(word_valid), 64'd0);
      check_eq("t1_busy_low", 64'(busy), 64'd0);
    end
    check_eq("t1_words_sent", 64'(words_sent), 64'd0);
    check_eq("t1_word_out", 64'(word_out), 64'd0);
    check_eq("t1_word_ch", 64'(word_ch), 64'd0);
    check_eq("t1_parity", 64'(word_parity), 64'd0);

    // Single channel 2 word.
    tick(1);
    load(2, 63'h0123_4567_89AB_CDEF);
    expect_word(2, 63'h0123_4567_89AB_CDEF);
    drain("t2", 30);
    check_eq("t2_strobe_count", 64'(strobe_ch.size()), 64'd1);
    check_eq("t2_handshakes", 64'(hs_cyc.size()), 64'd1);
    if (strobe_ch.size() == 1 && hs_cyc.size() == 1) begin
      check_eq("t2_strobe_ch", 64'(strobe_ch[0]), 64'd2);
      check_eq("t2_valid_latency", 64'(hs_cyc[0] - strobe_cyc[0]), 64'd1);
    end
    check_eq("t2_words_sent", 64'(words_sent), 64'd1);

    // All four channels requesting: round-robin 0,1,2,3,0 every 3 cycles.
    apply_reset();
    for (int i = 0; i < 5; i++) wv[i] = rand_word();
    load(0, wv[0]); load(0, wv[4]);
    load(1, wv[1]); load(2, wv[2]); load(3, wv[3]);
    expect_word(0, wv[0]); expect_word(1, wv[1]); expect_word(2, wv[2]);
    expect_word(3, wv[3]); expect_word(0, wv[4]);
    drain("t3", 60);
    check_eq("t3_strobe_count", 64'(strobe_ch.size()), 64'd5);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check_eq("t3_grant_spacing", 64'(strobe_cyc[i] - strobe_cyc[i-1]), 64'd3);
    check_eq("t3_words_sent", 64'(words_sent), 64'd5);

    // Half-full priority: ch3 first, then round-robin from ch0.
    apply_reset();
    fifo_half = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      wv[i] = rand_word();
      load(i, wv[i]);
    end
    expect_word(3, wv[3]); expect_word(0, wv[0]);
    expect_word(1, wv[1]); expect_word(2, wv[2]);
    drain("t4", 60);
    if (strobe_ch.size() >= 2) begin
      check_eq("t4_first_grant", 64'(strobe_ch[0]), 64'd3);
      check_eq("t4_second_grant", 64'(strobe_ch[1]), 64'd0);
    end
    check_eq("t4_words_sent", 64'(words_sent), 64'd4);

    // Backpressure: word held stable, no new strobe while waiting.
    apply_reset();
    word_ready = 1'b0;
    wv[0] = rand_word();
    wv[1] = rand_word();
    load(1, wv[0]);
    expect_word(1, wv[0]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!word_valid && n < 20);
    check_eq("t5_valid_seen", 64'(word_valid), 64'd1);
    held_word = word_out;
    check_eq("t5_first_word", 64'(held_word), 64'(wv[0]));
    @(posedge clk);
    #1;
    fifo_data[1*W +: W] = ~wv[0];
    load(2, wv[1]);
    expect_word(2, wv[1]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t5_hold_word", 64'(word_out), 64'(wv[0]));
      check_eq("t5_hold_ch", 64'(word_ch), 64'd1);
      check_eq("t5_hold_valid", 64'(word_valid), 64'd1);
      check_eq("t5_no_strobe", 64'(read_n), 64'hF);
    end
    @(posedge clk);
    #1 word_ready = 1'b1;
    drain("t5", 40);
    check_eq("t5_words_sent", 64'(words_sent), 64'd2);

    // Reset during SEND after seven words; next grant restarts at ch0.
    apply_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) wv[i] = rand_word();
    load(0, wv[0]); load(0, wv[4]);
    load(1, wv[1]); load(1, wv[5]); load(1, wv[7]);
    load(2, wv[2]); load(2, wv[6]);
    load(3, wv[3]);
    expect_word(0, wv[0]); expect_word(1, wv[1]); expect_word(2, wv[2]);
    expect_word(3, wv[3]); expect_word(0, wv[4]); expect_word(1, wv[5]);
    expect_word(2, wv[6]); expect_word(1, wv[7]);
    n = 0;
    while (words_sent != 16'd7 && n < 100) begin
      tick(1);
      n++;
    end
    word_ready = 1'b0;
    check_eq("t6_seven_sent", 64'(words_sent), 64'd7);
    n = 0;
    while (!word_valid && n < 20) begin
      tick(1);
      n++;
    end
    check_eq("t6_eighth_valid", 64'(word_valid), 64'd1);
    check_eq("t6_eighth_ch", 64'(word_ch), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_async_valid", 64'(word_valid), 64'd0);
    check_eq("t6_async_count", 64'(words_sent), 64'd0);
    check_eq("t6_async_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    clear_logs();
    word_ready = 1'b1;
    wv[0] = rand_word();
    wv[1] = rand_word();
    load(2, wv[1]);
    load(0, wv[0]);
    expect_word(0, wv[0]);
    expect_word(2, wv[1]);
    drain("t6", 40);
    if (strobe_ch.size() >= 1)
      check_eq("t6_restart_ch0", 64'(strobe_ch[0]), 64'd0);
    check_eq("t6_words_sent", 64'(words_sent), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Drains NUM_CH channel FIFOs (pulse-controlled latch FIFOs with active-low read strobe) into one shared output word stream toward the off-chip serializer.
- Each grant issues exactly one read strobe to one FIFO, captures the word, appends channel ID and an odd-parity bit, and holds the result under a valid/ready handshake.
- Arbitration is round-robin, with optional priority for channels whose FIFO is half full.

Parameters:
- NUM_CH, 4: number of channel FIFOs drained.
- FIFO_WIDTH, 63: width of each FIFO word.
- CH_BITS, $clog2(NUM_CH): width of the channel ID (minimum 1).
- PRIO_HALF, 1: 1 = half-full channels win over non-half-full channels; 0 = plain round-robin.
- CNT_WIDTH, 16: width of the words_sent counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  allows new grants; does not abort a grant already in progress.
- fifo_empty  input  NUM_CH  per-channel FIFO empty flag, bit i = channel i.
- fifo_half  input  NUM_CH  per-channel FIFO half-full flag.
- fifo_data  input  NUM_CH*FIFO_WIDTH  per-channel FIFO data_out, flattened; channel i at [i*FIFO_WIDTH +: FIFO_WIDTH].
- read_n  output  NUM_CH  per-channel active-low read strobe, registered.
- word_out  output  FIFO_WIDTH  captured FIFO word.
- word_ch  output  CH_BITS  channel that sourced word_out.
- word_parity  output  1  odd parity over {word_ch, word_out}; XOR of all those bits plus word_parity equals 1.
- word_valid  output  1  word_out/word_ch/word_parity are valid.
- word_ready  input  1  downstream accepts the word.
- busy  output  1  high in any state other than IDLE.
- words_sent  output  CNT_WIDTH  count of completed handshakes; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; read_n = all 1s; word_valid = 0.
  - word_out, word_ch, word_parity = 0; rr_ptr = 0; words_sent = 0; busy = 0.
- FSM states: IDLE, READ, SEND.
- IDLE:
  - req = ~fifo_empty.
  - If enable=1 and req != 0: select grant g, register it, drive read_n[g] low for the next cycle, go to READ.
  - Otherwise stay in IDLE.
- Grant selection:
  - If PRIO_HALF=1 and (req & fifo_half) != 0, search only that set; otherwise search req.
  - Search starts at index rr_ptr, ascending, wrapping at NUM_CH; first set bit wins.
  - On grant: rr_ptr <= (g == NUM_CH-1) ? 0 : g+1.
- READ (exactly one cycle):
  - read_n[g] = 0; all other read_n bits = 1.
  - The FIFO updates data_out on the falling edge within this cycle.
  - At the posedge ending READ: capture fifo_data[g] into word_out, g into word_ch, compute word_parity; set word_valid = 1; read_n returns all 1s; go to SEND.
- SEND:
  - Hold word_out, word_ch, word_parity and word_valid stable while word_ready = 0.
  - At a posedge with word_ready = 1: word_valid <= 0; words_sent <= words_sent + 1; go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> read_n low in cycle 1 -> word_valid high from cycle 2.
  - Minimum 3 cycles per word. The mandatory IDLE cycle lets FIFO flags settle after the pointer increment.
- Strobe rules:
  - At most one read_n bit low in any cycle.
  - No read_n bit low outside READ.
  - Never strobe a channel whose fifo_empty was 1 in the grant cycle.
- enable deasserted during READ or SEND: the current word completes normally; no new grant afterwards.
- fifo_empty of the granted channel changing during READ/SEND: ignored.
- word_ready high in IDLE or READ: ignored; no count increment.
- Reset mid-SEND: word is discarded, word_valid drops immediately, counter clears.
- NUM_CH = 1: rr_ptr stays 0; word_ch = 0.

Test Plan:
- Reset, all fifo_empty = 1, enable = 1 for 20 cycles -> read_n stays all 1s, word_valid = 0, busy = 0, words_sent = 0.
- Channel 2 only non-empty, fifo_data ch2 = 63'h0123_4567_89AB_CDEF, word_ready = 1 -> read_n = 4'b1011 for one cycle, word_valid two cycles after the grant, word_ch = 2, parity odd, words_sent = 1.
- All four channels non-empty, fifo_half = 0, word_ready = 1 -> grant order 0,1,2,3,0 with one grant every 3 cycles.
- PRIO_HALF = 1, all non-empty, only ch3 half-full, rr_ptr = 0 -> ch3 granted first, then ch0.
- word_ready held low 5 cycles in SEND with the FIFO input changed meanwhile -> word_out, word_ch, word_parity unchanged; no strobe issued; accepted on the 6th cycle.
- reset_n pulsed low mid-SEND with words_sent = 7 -> word_valid = 0 and words_sent = 0 asynchronously; after release the next grant starts from ch0.
